// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS sequencer: steps the shared datapath through fetch/decode/exec/mem/wb.
// Latency: 3 cycles (beq/j), 4 (ALU ops, sw), 5 (lw), plus one per mem_ready=0 cycle.
// Backpressure: FETCH and MEM hold with mem_req/iord/mem_we stable until mem_ready.
module multi_cycle_ctrl (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic       if_extend,
    output logic [4:0] aluop,
    output logic       illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_RTYPE, CL_ADDI, CL_ADDIU, CL_ANDI, CL_ORI, CL_LUI,
        CL_LW, CL_SW, CL_BEQ, CL_J, CL_BAD
    } iclass_t;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_ADDU = 5'b00001;
    localparam logic [4:0] ALU_SUBU = 5'b00010;
    localparam logic [4:0] ALU_AND  = 5'b00011;
    localparam logic [4:0] ALU_OR   = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b00101;
    localparam logic [4:0] ALU_LUI  = 5'b00110;

    state_t     state;
    iclass_t    iclass;
    logic [4:0] r_aluop;

    // Classify the instruction held in IR; R-type funct also selects its ALU operation.
    always_comb begin
        iclass  = CL_BAD;
        r_aluop = ALU_ADD;
        case (op)
            6'b000000: begin
                iclass = CL_RTYPE;
                case (funct)
                    6'b100000: r_aluop = ALU_ADD;
                    6'b100001: r_aluop = ALU_ADDU;
                    6'b100011: r_aluop = ALU_SUBU;
                    6'b100100: r_aluop = ALU_AND;
                    6'b100101: r_aluop = ALU_OR;
                    6'b101010: r_aluop = ALU_SLT;
                    default:   iclass  = CL_BAD;
                endcase
            end
            6'b001000: iclass = CL_ADDI;
            6'b001001: iclass = CL_ADDIU;
            6'b001100: iclass = CL_ANDI;
            6'b001101: iclass = CL_ORI;
            6'b001111: iclass = CL_LUI;
            6'b100011: iclass = CL_LW;
            6'b101011: iclass = CL_SW;
            6'b000100: iclass = CL_BEQ;
            6'b000010: iclass = CL_J;
            default:   iclass = CL_BAD;
        endcase
    end

    // Sequencer state and sticky trap flag; TRAP is left only through rstn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= FETCH;
            illegal <= 1'b0;
        end else begin
            case (state)
                FETCH:  if (mem_ready) state <= DECODE;
                DECODE: begin
                    if (iclass == CL_BAD) begin
                        state   <= TRAP;
                        illegal <= 1'b1;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    case (iclass)
                        CL_LW, CL_SW:  state <= MEM;
                        CL_BEQ, CL_J:  state <= FETCH;
                        default:       state <= WB;
                    endcase
                end
                MEM:    if (mem_ready) state <= (iclass == CL_SW) ? FETCH : WB;
                WB:     state <= FETCH;
                TRAP:   state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    // Datapath controls decoded from state and instruction class; forced low while in reset.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        if_extend  = 1'b0;
        aluop      = ALU_ADD;
        if (rstn) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                EXEC: begin
                    case (iclass)
                        CL_RTYPE: aluop = r_aluop;
                        CL_ADDI:  begin alu_src = 1'b1; if_extend = 1'b1; aluop = ALU_ADD;  end
                        CL_ADDIU: begin alu_src = 1'b1; if_extend = 1'b1; aluop = ALU_ADDU; end
                        CL_ANDI:  begin alu_src = 1'b1; aluop = ALU_AND; end
                        CL_ORI:   begin alu_src = 1'b1; aluop = ALU_OR;  end
                        CL_LUI:   begin alu_src = 1'b1; aluop = ALU_LUI; end
                        CL_LW, CL_SW: begin alu_src = 1'b1; if_extend = 1'b1; aluop = ALU_ADDU; end
                        CL_BEQ: begin
                            aluop    = ALU_SUBU;
                            pc_write = zero;
                            pc_src   = 2'b01;
                        end
                        CL_J: begin
                            pc_write = 1'b1;
                            pc_src   = 2'b10;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (iclass == CL_SW);
                end
                WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (iclass != CL_RTYPE);
                    mem_to_reg = (iclass == CL_LW);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed check of multi_cycle_ctrl: per-instruction vector table plus hand sequences.
// Latency: n/a (bench).
// Backpressure: mem_ready driven low in FETCH/MEM to exercise the hold behaviour.
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, reg_dst, mem_to_reg, alu_src, if_extend;
    logic [4:0] aluop;
    logic       illegal;

    int total = 0;
    int bad   = 0;

    multi_cycle_ctrl dut (
        .clk(clk), .rstn(rstn), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .if_extend(if_extend),
        .aluop(aluop), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         lat;
        logic [9:0] exec_exp;   // {aluop, alu_src, if_extend, pc_write, pc_src}
        logic       has_mem;
        logic       mem_we;
        int         nregw;
        logic [1:0] wb_exp;     // {reg_dst, mem_to_reg}
        int         npcw;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting at posedge+1 of a FETCH cycle, mem_ready held high.
    task automatic run_vec(input vec_t v);
        int nregw, npcw, nirw;
        nregw = 0; npcw = 0; nirw = 0;
        op = v.op; funct = v.funct; zero = v.zero; mem_ready = 1'b1;
        for (int c = 0; c < v.lat; c++) begin
            #2;
            npcw += int'(pc_write);
            nirw += int'(ir_write);
            if (reg_write) begin
                nregw++;
                chk({v.name, " wb"}, 16'({reg_dst, mem_to_reg}), 16'(v.wb_exp));
            end
            if (c == 0) chk({v.name, " fetch"}, 16'({mem_req, iord, mem_we}), 16'b100);
            if (c == 1) chk({v.name, " decode"}, 16'({mem_req, ir_write, pc_write, reg_write}), 16'h0);
            if (c == 2) chk({v.name, " exec"},
                            16'({aluop, alu_src, if_extend, pc_write, pc_src}), 16'(v.exec_exp));
            if (c == 3 && v.has_mem)
                chk({v.name, " mem"}, 16'({mem_req, iord, mem_we}), 16'({2'b11, v.mem_we}));
            step();
        end
        chk({v.name, " nregw"}, 16'(nregw), 16'(v.nregw));
        chk({v.name, " npcw"}, 16'(npcw), 16'(v.npcw));
        chk({v.name, " nirw"}, 16'(nirw), 16'd1);
        #1;
        chk({v.name, " back_fetch"}, 16'({mem_req, iord, ir_write}), 16'b101);
    endtask

    // Illegal encoding: trap after DECODE, stay silent, recover on an rstn pulse.
    task automatic trap_test(input string name, input logic [5:0] o, input logic [5:0] f);
        int viol;
        op = o; funct = f; mem_ready = 1'b1; zero = 1'b0;
        step();                                         // FETCH -> DECODE
        #2;
        chk({name, " decode_illegal"}, 16'(illegal), 16'd0);
        step();                                         // now TRAP
        viol = 0;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (illegal !== 1'b1 || mem_req || mem_we || ir_write || pc_write || reg_write)
                viol++;
            step();
        end
        chk({name, " trap_hold"}, 16'(viol), 16'd0);
        #2;
        mem_ready = 1'b0;
        rstn = 1'b0;
        #1;
        chk({name, " trap_rst"}, 16'({illegal, mem_req}), 16'b00);
        #1;
        rstn = 1'b1;
        #1;
        chk({name, " trap_release"}, 16'({illegal, mem_req, ir_write}), 16'b010);
        step();
        mem_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             name    op         funct      z  lat exec_exp           mem we regw wb     pcw
        vecs[0]  = '{"addu",  6'b000000, 6'b100001, 0, 4, 10'b00001_0_0_0_00, 0, 0, 1, 2'b00, 1};
        vecs[1]  = '{"add",   6'b000000, 6'b100000, 0, 4, 10'b00000_0_0_0_00, 0, 0, 1, 2'b00, 1};
        vecs[2]  = '{"subu",  6'b000000, 6'b100011, 0, 4, 10'b00010_0_0_0_00, 0, 0, 1, 2'b00, 1};
        vecs[3]  = '{"and",   6'b000000, 6'b100100, 0, 4, 10'b00011_0_0_0_00, 0, 0, 1, 2'b00, 1};
        vecs[4]  = '{"or",    6'b000000, 6'b100101, 0, 4, 10'b00100_0_0_0_00, 0, 0, 1, 2'b00, 1};
        vecs[5]  = '{"slt",   6'b000000, 6'b101010, 0, 4, 10'b00101_0_0_0_00, 0, 0, 1, 2'b00, 1};
        vecs[6]  = '{"addi",  6'b001000, 6'b100010, 0, 4, 10'b00000_1_1_0_00, 0, 0, 1, 2'b10, 1};
        vecs[7]  = '{"addiu", 6'b001001, 6'b100010, 0, 4, 10'b00001_1_1_0_00, 0, 0, 1, 2'b10, 1};
        vecs[8]  = '{"andi",  6'b001100, 6'b100010, 0, 4, 10'b00011_1_0_0_00, 0, 0, 1, 2'b10, 1};
        vecs[9]  = '{"ori",   6'b001101, 6'b100010, 0, 4, 10'b00100_1_0_0_00, 0, 0, 1, 2'b10, 1};
        vecs[10] = '{"lui",   6'b001111, 6'b100010, 0, 4, 10'b00110_1_0_0_00, 0, 0, 1, 2'b10, 1};
        vecs[11] = '{"lw",    6'b100011, 6'b000000, 0, 5, 10'b00001_1_1_0_00, 1, 0, 1, 2'b11, 1};
        vecs[12] = '{"sw",    6'b101011, 6'b000000, 0, 4, 10'b00001_1_1_0_00, 1, 1, 0, 2'b00, 1};
        vecs[13] = '{"beq_t", 6'b000100, 6'b000000, 1, 3, 10'b00010_0_0_1_01, 0, 0, 0, 2'b00, 2};
        vecs[14] = '{"beq_n", 6'b000100, 6'b000000, 0, 3, 10'b00010_0_0_0_01, 0, 0, 0, 2'b00, 1};
        vecs[15] = '{"j",     6'b000010, 6'b000000, 0, 3, 10'b00000_0_0_1_10, 0, 0, 0, 2'b00, 2};

        // Reset: outputs quiet while rstn low, FETCH request after release.
        rstn = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        step(); step();
        #2;
        chk("rst_outputs", 16'({mem_req, ir_write, pc_write, reg_write, mem_we, illegal}), 16'h0);
        rstn = 1'b1;
        #1;
        chk("rst_release", 16'({mem_req, iord, mem_we, ir_write, illegal}), 16'b10000);
        step();
        // FETCH waits while mem_ready is low.
        #2;
        chk("fetch_wait", 16'({mem_req, iord, ir_write, pc_write}), 16'b1000);
        step();
        mem_ready = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // lw with two wait cycles in MEM: seven cycles total.
        begin
            int hold_bad;
            hold_bad = 0;
            op = 6'b100011; funct = 6'b000000; mem_ready = 1'b1;
            step(); step(); step();                         // FETCH, DECODE, EXEC
            for (int c = 0; c < 3; c++) begin
                mem_ready = (c == 2);
                #2;
                if ({mem_req, iord, mem_we, reg_write} !== 4'b1100) hold_bad++;
                step();
            end
            chk("lw_mem_hold", 16'(hold_bad), 16'd0);
            mem_ready = 1'b1;
            #2;
            chk("lw_wait_wb", 16'({reg_write, reg_dst, mem_to_reg}), 16'b111);
            step();
            #1;
            chk("lw_wait_fetch", 16'({mem_req, iord, ir_write}), 16'b101);
        end

        // Reset asserted during the MEM cycle of sw.
        begin
            int post_bad;
            post_bad = 0;
            op = 6'b101011; funct = 6'b000000; mem_ready = 1'b1;
            step(); step(); step();                         // into MEM
            mem_ready = 1'b0;
            #2;
            chk("sw_mem_we", 16'({mem_req, iord, mem_we}), 16'b111);
            rstn = 1'b0;
            #1;
            chk("sw_rst_async", 16'({mem_req, iord, mem_we, pc_write, reg_write}), 16'h0);
            step();
            #2;
            rstn = 1'b1;
            for (int c = 0; c < 3; c++) begin
                #1;
                if ({mem_req, iord, mem_we, reg_write, pc_write} !== 5'b10000) post_bad++;
                step();
                #1;
            end
            chk("sw_rst_resume", 16'(post_bad), 16'd0);
            #0;
        end
        // Align to posedge+1 and confirm a normal instruction runs after the abandoned access.
        step();
        run_vec(vecs[0]);

        trap_test("trap_r0", 6'b000000, 6'b000000);
        trap_test("trap_op3f", 6'b111111, 6'b100000);
        run_vec(vecs[9]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
